// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer that turns a valid/ready sample stream into uninterrupted
// N-sample bursts for the streaming FFT. Optional zero padding: FEEDER_ZERO_PAD_EN.
module fft_frame_feeder #(
    parameter int N    = 32,
    parameter int IN_W = 12,
    parameter int GAP  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [IN_W-1:0] s_data_r,
    input  logic signed [IN_W-1:0] s_data_i,
    input  logic                   flush,
`ifdef FEEDER_ZERO_PAD_EN
    input  logic                   s_last,
`endif
    output logic                   in_valid,
    output logic signed [IN_W-1:0] din_r,
    output logic signed [IN_W-1:0] din_i,
    output logic                   frame_start,
    output logic [7:0]             frames_sent
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    // The IDLE cycle after S_GAP is itself an idle cycle, so S_GAP lasts GAP-1 cycles.
    localparam logic [7:0] GAP_LOAD = (GAP > 1) ? 8'(GAP - 2) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               run_q, run_d;
    logic [1:0]         full_q, full_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [AW-1:0]      wr_idx_q, wr_idx_d;
    logic [AW-1:0]      rd_idx_q, rd_idx_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic               in_valid_q, in_valid_d;
    logic [2*IN_W-1:0]  din_q, din_d;
    logic               frame_start_q, frame_start_d;
    logic [7:0]         frames_sent_q, frames_sent_d;
`ifdef FEEDER_ZERO_PAD_EN
    logic               pad_q, pad_d;
`endif

    logic               full_set;
    logic               full_clr;
    logic               wr_last;
    logic               mem_we;
    logic [AW:0]        mem_waddr;
    logic [2*IN_W-1:0]  mem_wdata;
    logic [2*IN_W-1:0]  mem_rdata;
    logic [2*IN_W-1:0]  mem_q [2*N];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_q[{rd_bank_q, rd_idx_q}];
    assign wr_last   = (wr_idx_q == LAST_IDX);
    assign run_d     = 1'b1;

`ifdef FEEDER_ZERO_PAD_EN
    assign s_ready = run_q && !full_q[wr_bank_q] && !pad_q;
`else
    assign s_ready = run_q && !full_q[wr_bank_q];
`endif

    // Write side: flush has priority over both padding and a live handshake.
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        full_set  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = {wr_bank_q, wr_idx_q};
        mem_wdata = {s_data_r, s_data_i};
`ifdef FEEDER_ZERO_PAD_EN
        pad_d     = pad_q;
`endif
        if (flush) begin
            wr_idx_d = '0;
`ifdef FEEDER_ZERO_PAD_EN
            pad_d    = 1'b0;
`endif
        end
`ifdef FEEDER_ZERO_PAD_EN
        else if (pad_q) begin
            mem_we    = 1'b1;
            mem_wdata = '0;
            wr_idx_d  = wr_idx_q + AW'(1);
            if (wr_last) begin
                full_set  = 1'b1;
                wr_bank_d = ~wr_bank_q;
                pad_d     = 1'b0;
            end
        end
`endif
        else if (s_valid && s_ready) begin
            mem_we   = 1'b1;
            wr_idx_d = wr_idx_q + AW'(1);
            if (wr_last) begin
                full_set  = 1'b1;
                wr_bank_d = ~wr_bank_q;
            end
`ifdef FEEDER_ZERO_PAD_EN
            else if (s_last) begin
                pad_d = 1'b1;
            end
`endif
        end
    end

    // Read FSM
    always_comb begin
        state_d       = state_q;
        rd_idx_d      = rd_idx_q;
        rd_bank_d     = rd_bank_q;
        gap_cnt_d     = gap_cnt_q;
        in_valid_d    = 1'b0;
        din_d         = din_q;
        frame_start_d = 1'b0;
        frames_sent_d = frames_sent_q;
        full_clr      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = S_BURST;
                    rd_idx_d = '0;
                end
            end
            S_BURST: begin
                in_valid_d    = 1'b1;
                din_d         = mem_rdata;
                frame_start_d = (rd_idx_q == '0);
                rd_idx_d      = rd_idx_q + AW'(1);
                if (rd_idx_q == LAST_IDX) begin
                    full_clr      = 1'b1;
                    rd_bank_d     = ~rd_bank_q;
                    frames_sent_d = frames_sent_q + 8'd1;
                    if (GAP > 1) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else if (GAP == 0 && full_q[~rd_bank_q]) begin
                        state_d  = S_BURST;
                        rd_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Set and clear never target the same bank: a bank is written only while empty.
    always_comb begin
        full_d = full_q;
        if (full_set) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (full_clr) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            run_q         <= 1'b0;
            full_q        <= 2'b00;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            gap_cnt_q     <= 8'd0;
            in_valid_q    <= 1'b0;
            din_q         <= '0;
            frame_start_q <= 1'b0;
            frames_sent_q <= 8'd0;
`ifdef FEEDER_ZERO_PAD_EN
            pad_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            gap_cnt_q     <= gap_cnt_d;
            in_valid_q    <= in_valid_d;
            din_q         <= din_d;
            frame_start_q <= frame_start_d;
            frames_sent_q <= frames_sent_d;
`ifdef FEEDER_ZERO_PAD_EN
            pad_q         <= pad_d;
`endif
        end
    end

    assign in_valid    = in_valid_q;
    assign din_r       = din_q[2*IN_W-1:IN_W];
    assign din_i       = din_q[IN_W-1:0];
    assign frame_start = frame_start_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: doc/fft_frame_feeder.md
Name: fft_frame_feeder

Overview:
- Transmit-side partner of the 32-point streaming FFT core.
- Accepts complex samples from upstream on a valid/ready handshake and buffers them into ping-pong frame banks.
- For each full frame, drives the FFT input with exactly N consecutive in_valid cycles (the core needs an uninterrupted burst).
- Sits directly in front of the FFT; its outputs connect one-to-one to the FFT's in_valid, din_r and din_i.

Parameters:
- N, 32, samples per frame; must be a power of two.
- IN_W, 12, sample width per component; matches the FFT din_r/din_i width.
- GAP, 0, minimum idle cycles (in_valid low) forced between consecutive bursts; range 0..255.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- s_valid  input  1  upstream sample valid.
- s_ready  output  1  feeder can accept a sample this cycle.
- s_data_r  input  IN_W  upstream real part, signed.
- s_data_i  input  IN_W  upstream imaginary part, signed.
- flush  input  1  discard the partially written frame.
- in_valid  output  1  burst strobe to the FFT.
- din_r  output  IN_W  sample to the FFT, real part, signed, registered.
- din_i  output  IN_W  sample to the FFT, imaginary part, signed, registered.
- frame_start  output  1  one-cycle pulse together with the first in_valid of each burst.
- frames_sent  output  8  count of completed bursts; wraps 255->0.

Behaviour:
- Reset (reset=0, asynchronous):
  - in_valid, din_r, din_i, frame_start, frames_sent = 0; s_ready = 0 while reset is asserted.
  - Both bank-full flags cleared; wr_bank = rd_bank = 0; wr_idx = 0; FSM = IDLE.
  - Buffer contents are don't-care.
  - Reset mid-burst aborts the burst immediately; the FFT sees in_valid fall asynchronously.
- Storage: 2 banks x N entries x 2*IN_W bits.
- Write side:
  - s_ready = !full[wr_bank], driven from registered flags only.
  - On the handshake (s_valid & s_ready): store to bank[wr_bank][wr_idx], then wr_idx++.
  - On accepting entry N-1: set full[wr_bank], toggle wr_bank, wr_idx wraps to 0.
- flush=1: wr_idx -> 0 next edge and any sample offered that cycle is dropped. Full banks and any burst in progress are unaffected. If flush and the final (N-1) handshake coincide, flush wins and the frame is discarded.
- Read FSM, states IDLE / BURST / GAP:
  - IDLE: if full[rd_bank], go to BURST and set rd_idx = 0.
  - BURST: each cycle drive in_valid=1 and the registered bank[rd_bank][rd_idx], then rd_idx++. frame_start=1 only on rd_idx 0.
  - After rd_idx N-1 has been driven: clear full[rd_bank], toggle rd_bank, frames_sent++.
  - From BURST: go to GAP if GAP>0; else go straight to BURST if the other bank is full (back-to-back bursts); else IDLE.
  - GAP: count GAP cycles with in_valid=0, then go to IDLE.
- Latency: in_valid first goes high on the 2nd rising edge after the edge that accepted the frame's last sample.
- Outputs hold their last value when in_valid=0; din is not zeroed.
- Simultaneous events: a bank cleared by the read side in cycle t shows as s_ready=1 in cycle t+1 (no combinational bypass). Write and read on different banks in the same cycle are legal.
- Both banks full: s_ready=0; upstream stalls with no data loss.
- Samples pass through unmodified in order; no arithmetic.

Optional Feature:
- Macro: FEEDER_ZERO_PAD_EN.
- Defined:
  - Adds input s_last (1 bit).
  - A handshake with s_last=1 at wr_idx<N-1 enters a PAD sub-state: s_ready=0, and one zero entry per cycle is written until entry N-1.
  - The bank is then marked full as normal. s_last at wr_idx N-1 behaves as a normal frame end.
  - flush during PAD aborts the padding and discards the frame.
- Not defined: port s_last is absent and frames are always exactly N accepted samples.

Test Plan:
- Reset, then 32 samples with s_valid held high (values k+1 real, -(k+1) imag) -> in_valid high for exactly 32 consecutive cycles starting 2 edges after the last accept. din_r sequence is 1..32, din_i is -1..-32. frame_start on the first cycle only; frames_sent=1.
- 64 samples back-to-back with GAP=0 -> two bursts with no idle cycle between them; s_ready never low; frames_sent=2.
- 96 samples with GAP=4 and s_valid always high -> s_ready drops after the second frame fills and recovers one cycle after the first burst ends; exactly 4 idle cycles between bursts; no sample lost.
- 10 samples, flush pulse, then 32 samples (values 100..131) -> a single burst carrying 100..131; the first 10 never appear.
- Assert reset at burst cycle 15 -> in_valid=0 and frames_sent=0 immediately. After release, 32 new samples produce a clean full burst.
- With FEEDER_ZERO_PAD_EN: 5 samples, the 5th with s_last=1 -> a burst of 5 data samples followed by 27 zeros; s_ready low for the 27 pad cycles.
